// File: rtl/vga_timing_pkg.sv
// Purpose: shared 640x480@60 timing constants, counter/sync types and a window helper.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
// Used by vga_sync_gen and by the pattern renderer so both agree on frame geometry.
package vga_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 800

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 525

  // Sync windows are half-open: [START, END)
  localparam int H_SYNC_START = H_ACTIVE + H_FP;               // 656
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;         // 752
  localparam int V_SYNC_START = V_ACTIVE + V_FP;               // 490
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;         // 492

  localparam int CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic von;
  } sync_t;

  function automatic logic in_window(input cnt_t c, input int lo, input int hi);
    return (int'(c) >= lo) && (int'(c) < hi);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Purpose: fixed-depth shift register with a per-bit reset value.
// Latency: DEPTH cycles from din to dout.
// Backpressure: none; shifts every cycle.
// Ports: VGA_clk, rst (async, active-high), din[WIDTH], dout[WIDTH].
module vga_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             VGA_clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge VGA_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_sync_gen.sv
// Purpose: 640x480@60 VGA timing; drives renderer coords, aligns sync with returned RGB.
// Latency: xpos/ypos are the counters; hsync/vsync/video_on/vga_* lag them by PIPE_DLY+1.
// Backpressure: none; free-running, renderer must honour the fixed PIPE_DLY latency.
// Ports: VGA_clk, rst (async, active-high); out xpos/ypos[10], frame_start;
//        in pat_r/g/b[4]; out hsync, vsync, video_on, vga_r/g/b[4].
// Build option: VGA_SYNC_BLANK_EN forces vga_r/g/b to 0 outside the active area.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int   H_FP     = vga_timing_pkg::H_FP,
  parameter int   H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int   H_BP     = vga_timing_pkg::H_BP,
  parameter int   V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int   V_FP     = vga_timing_pkg::V_FP,
  parameter int   V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int   V_BP     = vga_timing_pkg::V_BP,
  parameter logic SYNC_POL = 1'b0,
  parameter int   PIPE_DLY = 2
) (
  input  logic       VGA_clk,
  input  logic       rst,
  output logic [9:0] xpos,
  output logic [9:0] ypos,
  output logic       frame_start,
  input  logic [3:0] pat_r,
  input  logic [3:0] pat_g,
  input  logic [3:0] pat_b,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b
);

  localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam sync_t SYNC_IDLE = '{hs: ~SYNC_POL, vs: ~SYNC_POL, von: 1'b0};

  generate
    if (PIPE_DLY < 1 || PIPE_DLY > 4) begin : g_bad_pipe_dly
      $error("vga_sync_gen: PIPE_DLY=%0d outside legal range 1..4", PIPE_DLY);
    end
  endgenerate

  cnt_t  h_cnt, v_cnt;
  logic  run;
  logic  h_last, v_last;
  sync_t sync_raw, sync_dly;

  assign h_last = (h_cnt == cnt_t'(H_TOT - 1));
  assign v_last = (v_cnt == cnt_t'(V_TOT - 1));

  // The first clock after reset holds 0,0 and raises frame_start, so pixel
  // (0,0) is presented with its frame marker before counting begins.
  always_ff @(posedge VGA_clk or posedge rst) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      run         <= 1'b0;
      frame_start <= 1'b0;
    end else if (!run) begin
      run         <= 1'b1;
      frame_start <= 1'b1;
    end else begin
      frame_start <= h_last && v_last;
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + cnt_t'(1);
      end else begin
        h_cnt <= h_cnt + cnt_t'(1);
      end
    end
  end

  assign xpos = h_cnt;
  assign ypos = v_cnt;

  // Raw timing is held idle during the start-up hold cycle so the repeated
  // 0,0 count does not produce a phantom active pixel down the delay line.
  always_comb begin
    sync_raw = SYNC_IDLE;
    if (run) begin
      sync_raw.hs  = in_window(h_cnt, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
      sync_raw.vs  = in_window(v_cnt, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
      sync_raw.von = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
    end
  end

  // Matches the renderer latency; the output register below adds the final
  // stage shared with the RGB capture.
  vga_delay_line #(
    .WIDTH   ($bits(sync_t)),
    .DEPTH   (PIPE_DLY),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_dly (
    .VGA_clk (VGA_clk),
    .rst     (rst),
    .din     (sync_raw),
    .dout    (sync_dly)
  );

  always_ff @(posedge VGA_clk or posedge rst) begin
    if (rst) begin
      hsync    <= SYNC_IDLE.hs;
      vsync    <= SYNC_IDLE.vs;
      video_on <= 1'b0;
      vga_r    <= 4'h0;
      vga_g    <= 4'h0;
      vga_b    <= 4'h0;
    end else begin
      hsync    <= sync_dly.hs;
      vsync    <= sync_dly.vs;
      video_on <= sync_dly.von;
`ifdef VGA_SYNC_BLANK_EN
      // Gate on the value being loaded into video_on so colour and the
      // active flag change in the same cycle at the connector.
      vga_r    <= sync_dly.von ? pat_r : 4'h0;
      vga_g    <= sync_dly.von ? pat_g : 4'h0;
      vga_b    <= sync_dly.von ? pat_b : 4'h0;
`else
      vga_r    <= pat_r;
      vga_g    <= pat_g;
      vga_b    <= pat_b;
`endif
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Purpose: self-checking bench for vga_sync_gen with a 2-cycle renderer model.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_vga_sync_gen;

  // Horizontal timing is the 640-wide default; vertical timing is shortened to
  // 10 lines per frame (4 active, 2 fp, 2 sync, 2 bp) -> vsync lines 6..7.
  localparam int H_TOT = 800;
  localparam int V_TOT = 10;
  localparam int FRAME = H_TOT * V_TOT;   // 8000

`ifdef VGA_SYNC_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic       VGA_clk = 1'b0;
  logic       rst     = 1'b1;
  logic [9:0] xpos, ypos;
  logic       frame_start, hsync, vsync, video_on;
  logic [3:0] pat_r = 4'h0, pat_g = 4'h0, pat_b = 4'h0;
  logic [3:0] vga_r, vga_g, vga_b;

  always #20 VGA_clk = ~VGA_clk;

  vga_sync_gen #(
    .V_ACTIVE (4),
    .V_FP     (2),
    .V_SYNC   (2),
    .V_BP     (2),
    .SYNC_POL (1'b0),
    .PIPE_DLY (2)
  ) dut (
    .VGA_clk     (VGA_clk),
    .rst         (rst),
    .xpos        (xpos),
    .ypos        (ypos),
    .frame_start (frame_start),
    .pat_r       (pat_r),
    .pat_g       (pat_g),
    .pat_b       (pat_b),
    .hsync       (hsync),
    .vsync       (vsync),
    .video_on    (video_on),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Renderer model: colour for coordinate X is presented two cycles after X.
  logic [3:0] p1_r = 4'h0, p2_r = 4'h0, p1_g = 4'h0, p2_g = 4'h0, p1_b = 4'h0, p2_b = 4'h0;
  logic       pat_const = 1'b0;

  task automatic step();
    @(negedge VGA_clk);
    if (pat_const) begin
      pat_r = 4'hF; pat_g = 4'hF; pat_b = 4'hF;
    end else begin
      pat_r = p2_r; pat_g = p2_g; pat_b = p2_b;
    end
    p2_r = p1_r; p1_r = xpos[3:0];
    p2_g = p1_g; p1_g = xpos[7:4];
    p2_b = p1_b; p1_b = ypos[3:0];
  endtask

  logic [9:0] x_hist   [1600];
  logic [9:0] y_hist   [1600];
  logic       hs_hist  [1600];
  logic       von_hist [1600];
  logic [3:0] vr_hist  [1600];

  int fs_at [4];
  int fs_n, vs_n, vs_first, von_frame, f_cnt, gate_bad, hs_low, von_line;
  int x_end, y_end, x_new, y_new;
  logic [3:0] exp_c;
  bit found;

  initial begin
    fs_n = 0; vs_n = 0; vs_first = -1; von_frame = 0; f_cnt = 0; gate_bad = 0;
    hs_low = 0; von_line = 0; x_end = -1; y_end = -1; x_new = -1; y_new = -1;
    for (int k = 0; k < 4; k++) fs_at[k] = -1;

    // Reset held 5 cycles
    rst = 1'b1;
    repeat (5) step();
    check("rst_xpos",     32'(xpos), 0);
    check("rst_ypos",     32'(ypos), 0);
    check("rst_hsync",    32'(hsync), 1);
    check("rst_vsync",    32'(vsync), 1);
    check("rst_video_on", 32'(video_on), 0);
    check("rst_fs",       32'(frame_start), 0);
    check("rst_vga_r",    32'(vga_r), 0);
    rst = 1'b0;

    for (int i = 0; i < 3 * FRAME; i++) begin
      step();
      if (i == 2 * FRAME) pat_const = 1'b1;
      if (i < 1600) begin
        x_hist[i] = xpos; y_hist[i] = ypos; hs_hist[i] = hsync;
        von_hist[i] = video_on; vr_hist[i] = vga_r;
      end
      if (frame_start) begin
        if (fs_n < 4) fs_at[fs_n] = i;
        fs_n++;
      end
      if (i < FRAME) begin
        if (!vsync) begin
          vs_n++;
          if (vs_first < 0) vs_first = i;
        end
        if (video_on) von_frame++;
      end
      if (i == FRAME - 1) begin x_end = int'(xpos); y_end = int'(ypos); end
      if (i == FRAME)     begin x_new = int'(xpos); y_new = int'(ypos); end
      if (i >= 2 * FRAME + 800 && i < 2 * FRAME + 1600) begin
        if (vga_r == 4'hF) f_cnt++;
        exp_c = (BLANK && !video_on) ? 4'h0 : 4'hF;
        if (vga_r !== exp_c || vga_g !== exp_c || vga_b !== exp_c) gate_bad++;
      end
    end

    // First cycle after release
    check("rel_xpos", 32'(x_hist[0]), 0);
    check("rel_ypos", 32'(y_hist[0]), 0);
    check("rel_fs",   32'(fs_at[0]), 0);
    check("rel_next_xpos", 32'(x_hist[1]), 1);

    // hsync: low for 96 cycles starting 3 cycles after xpos==656
    for (int k = 0; k < 800; k++) if (!hs_hist[k]) hs_low++;
    check("hs_x656",  32'(x_hist[656]), 656);
    check("hs_pre",   32'(hs_hist[658]), 1);
    check("hs_first", 32'(hs_hist[659]), 0);
    check("hs_last",  32'(hs_hist[754]), 0);
    check("hs_post",  32'(hs_hist[755]), 1);
    check("hs_width", 32'(hs_low), 96);

    // Line wrap 799 -> 0 with ypos increment in the same cycle
    check("wrap_x799", 32'(x_hist[799]), 799);
    check("wrap_x0",   32'(x_hist[800]), 0);
    check("wrap_y0",   32'(y_hist[799]), 0);
    check("wrap_y1",   32'(y_hist[800]), 1);

    // video_on window on line 1 and RGB alignment (pat_r = xpos[3:0])
    for (int k = 800; k < 1600; k++) if (von_hist[k]) von_line++;
    check("von_pre",   32'(von_hist[802]), 0);
    check("von_rise",  32'(von_hist[803]), 1);
    check("von_last",  32'(von_hist[1442]), 1);
    check("von_fall",  32'(von_hist[1443]), 0);
    check("von_width", 32'(von_line), 640);
    check("rgb_porch", 32'(vr_hist[802]), BLANK ? 0 : 15);
    check("rgb_x0",    32'(vr_hist[803]), 0);
    check("rgb_x1",    32'(vr_hist[804]), 1);
    check("rgb_x15",   32'(vr_hist[818]), 15);
    check("rgb_x16",   32'(vr_hist[819]), 0);

    // Frame timing
    check("fs_period0", 32'(fs_at[1] - fs_at[0]), FRAME);
    check("fs_period1", 32'(fs_at[2] - fs_at[1]), FRAME);
    check("fs_count",   32'(fs_n), 3);
    check("vs_first",   32'(vs_first), 6 * 800 + 3);
    check("vs_width",   32'(vs_n), 2 * 800);
    check("von_frame",  32'(von_frame), 4 * 640);
    check("ywrap_xend", 32'(x_end), 799);
    check("ywrap_yend", 32'(y_end), V_TOT - 1);
    check("ywrap_xnew", 32'(x_new), 0);
    check("ywrap_ynew", 32'(y_new), 0);

    // Constant-F renderer: blanking gate
    check("blank_f_count", 32'(f_cnt), BLANK ? 640 : 800);
    check("blank_gate",    32'(gate_bad), 0);

    // Mid-frame reset at xpos=700, ypos=3 (inside the hsync pulse)
    found = 1'b0;
    for (int k = 0; k < 9000 && !found; k++) begin
      step();
      if (xpos == 10'd700 && ypos == 10'd3) found = 1'b1;
    end
    check("mid_found",     32'(found), 1);
    check("mid_hs_before", 32'(hsync), 0);
    rst = 1'b1;
    #1;
    check("mid_hsync",    32'(hsync), 1);
    check("mid_vsync",    32'(vsync), 1);
    check("mid_xpos",     32'(xpos), 0);
    check("mid_ypos",     32'(ypos), 0);
    check("mid_video_on", 32'(video_on), 0);
    check("mid_vga_r",    32'(vga_r), 0);
    step();
    rst = 1'b0;
    step();
    check("mid_rel_xpos", 32'(xpos), 0);
    check("mid_rel_ypos", 32'(ypos), 0);
    check("mid_rel_fs",   32'(frame_start), 1);
    step();
    check("mid_next_xpos",  32'(xpos), 1);
    check("mid_next_fs",    32'(frame_start), 0);
    check("mid_next_hsync", 32'(hsync), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
